// File: rtl/execute.sv
// -----------------------------------------------------------------------------
// execute
//
// EX stage of the 64-bit LEGv8 pipelined processor. Sits between the ID/EX
// and EX/MEM pipeline registers. It picks the ALU B operand, runs the ALU,
// computes the branch target and passes the store data through. It also keeps
// a registered NZCV condition-flag register.
//
// Optional build macro: EXECUTE_OUT_REG_EN
//   undefined (default) : zero_E, PCBranch_E, aluResult_E and writeData_E are
//                         purely combinational.
//   defined             : those four outputs are registered, giving 1-cycle
//                         latency, and cleared by reset. The flag register
//                         behaves the same in both builds.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   AluSrc       in   B operand select: 0 = readData2_E, 1 = signImm_E
//   AluControl   in   4-bit ALU operation code
//   PC_E         in   PC of the instruction in EX
//   signImm_E    in   sign-extended immediate (word offset for branches)
//   readData1_E  in   register operand A
//   readData2_E  in   register operand B / store data
//   setFlags_E   in   capture NZCV from this cycle's ALU operation
//   zero_E       out  ALU result is zero
//   PCBranch_E   out  branch target PC_E + (signImm_E << 2)
//   aluResult_E  out  ALU result
//   writeData_E  out  store data (readData2_E)
//   flags_E      out  registered {N,Z,C,V}
// -----------------------------------------------------------------------------
module execute #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         AluSrc,
  input  logic [3:0]   AluControl,
  input  logic [N-1:0] PC_E,
  input  logic [N-1:0] signImm_E,
  input  logic [N-1:0] readData1_E,
  input  logic [N-1:0] readData2_E,
  input  logic         setFlags_E,
  output logic         zero_E,
  output logic [N-1:0] PCBranch_E,
  output logic [N-1:0] aluResult_E,
  output logic [N-1:0] writeData_E,
  output logic [3:0]   flags_E
);

  // ALU operation codes
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_ORR  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [N:0]   add_full;
  logic [N:0]   sub_full;
  logic [N-1:0] alu_res;
  logic         alu_zero;
  logic [N-1:0] pc_branch;
  logic         flag_n;
  logic         flag_z;
  logic         flag_c;
  logic         flag_v;

  logic [3:0]   flags_d;
  logic [3:0]   flags_q;

  // Operand selection and the two wide adders. The subtract is done as
  // a + ~b + 1 so its carry out is the ARM-style "no borrow" flag.
  always_comb begin
    op_a     = readData1_E;
    op_b     = AluSrc ? signImm_E : readData2_E;
    add_full = {1'b0, op_a} + {1'b0, op_b};
    sub_full = {1'b0, op_a} + {1'b0, ~op_b} + {{N{1'b0}}, 1'b1};
  end

  // ALU result and NZCV. Carry and overflow only mean something for ADD and
  // SUB; every other operation reports them as zero.
  always_comb begin
    alu_res = '0;
    flag_c  = 1'b0;
    flag_v  = 1'b0;
    case (AluControl)
      OP_AND:  alu_res = op_a & op_b;
      OP_ORR:  alu_res = op_a | op_b;
      OP_ADD: begin
        alu_res = add_full[N-1:0];
        flag_c  = add_full[N];
        flag_v  = (op_a[N-1] == op_b[N-1]) && (add_full[N-1] != op_a[N-1]);
      end
      OP_SUB: begin
        alu_res = sub_full[N-1:0];
        flag_c  = sub_full[N];
        flag_v  = (op_a[N-1] != op_b[N-1]) && (sub_full[N-1] != op_a[N-1]);
      end
      OP_PASS: alu_res = op_b;
      OP_NOR:  alu_res = ~(op_a | op_b);
      default: alu_res = '0;
    endcase
    alu_zero = (alu_res == '0);
    flag_n   = alu_res[N-1];
    flag_z   = alu_zero;
  end

  // Branch target: shift drops bits past the MSB and the add wraps.
  always_comb begin
    pc_branch = PC_E + (signImm_E << 2);
  end

  // Flag register next state: reset beats a flag-setting instruction.
  always_comb begin
    flags_d = flags_q;
    if (reset) begin
      flags_d = 4'b0000;
    end else if (setFlags_E) begin
      flags_d = {flag_n, flag_z, flag_c, flag_v};
    end
  end

  always_ff @(posedge clk) begin
    flags_q <= flags_d;
  end

  assign flags_E = flags_q;

`ifdef EXECUTE_OUT_REG_EN
  logic         zero_d;
  logic         zero_q;
  logic [N-1:0] pc_branch_d;
  logic [N-1:0] pc_branch_q;
  logic [N-1:0] alu_result_d;
  logic [N-1:0] alu_result_q;
  logic [N-1:0] write_data_d;
  logic [N-1:0] write_data_q;

  // Registered datapath outputs, cleared by reset.
  always_comb begin
    if (reset) begin
      zero_d       = 1'b0;
      pc_branch_d  = '0;
      alu_result_d = '0;
      write_data_d = '0;
    end else begin
      zero_d       = alu_zero;
      pc_branch_d  = pc_branch;
      alu_result_d = alu_res;
      write_data_d = readData2_E;
    end
  end

  always_ff @(posedge clk) begin
    zero_q       <= zero_d;
    pc_branch_q  <= pc_branch_d;
    alu_result_q <= alu_result_d;
    write_data_q <= write_data_d;
  end

  assign zero_E      = zero_q;
  assign PCBranch_E  = pc_branch_q;
  assign aluResult_E = alu_result_q;
  assign writeData_E = write_data_q;
`else
  assign zero_E      = alu_zero;
  assign PCBranch_E  = pc_branch;
  assign aluResult_E = alu_res;
  assign writeData_E = readData2_E;
`endif

endmodule

// File: tb/tb_execute.sv
// -----------------------------------------------------------------------------
// tb_execute
//
// Scoreboard bench for the execute stage (default, combinational build).
// The stimulus process drives one directed vector per clock, just after the
// rising edge, and pushes the hand-computed expected outputs into a queue.
// The monitor samples the DUT on every falling edge and compares against the
// oldest queued entry. The expected flags in each entry are the value the
// flag register should hold during that vector's cycle, i.e. the result of
// the previous vectors' reset/setFlags_E requests.
// -----------------------------------------------------------------------------
module tb_execute;

  localparam int N = 64;

  typedef struct {
    logic         zero;
    logic [N-1:0] pcBranch;
    logic [N-1:0] aluResult;
    logic [N-1:0] writeData;
    logic [3:0]   flags;
  } expect_t;

  logic         clk;
  logic         reset;
  logic         AluSrc;
  logic [3:0]   AluControl;
  logic [N-1:0] PC_E;
  logic [N-1:0] signImm_E;
  logic [N-1:0] readData1_E;
  logic [N-1:0] readData2_E;
  logic         setFlags_E;
  logic         zero_E;
  logic [N-1:0] PCBranch_E;
  logic [N-1:0] aluResult_E;
  logic [N-1:0] writeData_E;
  logic [3:0]   flags_E;

  expect_t expQueue[$];
  int      assertCount = 0;
  int      failCount   = 0;
  int      vecIndex    = 0;

  execute #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .AluSrc      (AluSrc),
    .AluControl  (AluControl),
    .PC_E        (PC_E),
    .signImm_E   (signImm_E),
    .readData1_E (readData1_E),
    .readData2_E (readData2_E),
    .setFlags_E  (setFlags_E),
    .zero_E      (zero_E),
    .PCBranch_E  (PCBranch_E),
    .aluResult_E (aluResult_E),
    .writeData_E (writeData_E),
    .flags_E     (flags_E)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one vector just after the rising edge and queue its expectation.
  task automatic applyStimulus(
    input logic         rst,
    input logic         setF,
    input logic         src,
    input logic [3:0]   ctl,
    input logic [N-1:0] pc,
    input logic [N-1:0] imm,
    input logic [N-1:0] rd1,
    input logic [N-1:0] rd2,
    input logic         expZero,
    input logic [N-1:0] expPcb,
    input logic [N-1:0] expRes,
    input logic [N-1:0] expWd,
    input logic [3:0]   expFlags
  );
    expect_t e;
    @(posedge clk);
    #1;
    reset       = rst;
    setFlags_E  = setF;
    AluSrc      = src;
    AluControl  = ctl;
    PC_E        = pc;
    signImm_E   = imm;
    readData1_E = rd1;
    readData2_E = rd2;
    e.zero      = expZero;
    e.pcBranch  = expPcb;
    e.aluResult = expRes;
    e.writeData = expWd;
    e.flags     = expFlags;
    expQueue.push_back(e);
  endtask

  // Compare every output of the DUT against one scoreboard entry.
  task automatic checkOutput(input expect_t e, input int idx);
    assertCount++;
    if (zero_E !== e.zero) begin
      failCount++;
      $display("[TB] FAIL vec%0d zero_E: got %0b expected %0b", idx, zero_E, e.zero);
    end
    assertCount++;
    if (PCBranch_E !== e.pcBranch) begin
      failCount++;
      $display("[TB] FAIL vec%0d PCBranch_E: got %h expected %h", idx, PCBranch_E, e.pcBranch);
    end
    assertCount++;
    if (aluResult_E !== e.aluResult) begin
      failCount++;
      $display("[TB] FAIL vec%0d aluResult_E: got %h expected %h", idx, aluResult_E, e.aluResult);
    end
    assertCount++;
    if (writeData_E !== e.writeData) begin
      failCount++;
      $display("[TB] FAIL vec%0d writeData_E: got %h expected %h", idx, writeData_E, e.writeData);
    end
    assertCount++;
    if (flags_E !== e.flags) begin
      failCount++;
      $display("[TB] FAIL vec%0d flags_E: got %b expected %b", idx, flags_E, e.flags);
    end
  endtask

  // Monitor: sample away from the active edge and pop the scoreboard.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      if (expQueue.size() > 0) begin
        e = expQueue.pop_front();
        checkOutput(e, vecIndex);
        vecIndex++;
      end
    end
  end

  initial begin
    int drainWait;
    reset       = 1'b1;
    setFlags_E  = 1'b0;
    AluSrc      = 1'b0;
    AluControl  = 4'b0000;
    PC_E        = '0;
    signImm_E   = '0;
    readData1_E = '0;
    readData2_E = '0;
    repeat (2) @(posedge clk);

    // rst setF src ctl  PC  imm  rd1  rd2  | zero pcb res wd flags
    // 0: ORR with immediate; flags come out of reset as 0000
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0001, 64'd1, 64'd1, 64'd1, 64'd1,
                  1'b0, 64'd5, 64'd1, 64'd1, 4'b0000);
    // 1: AND giving zero
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000, 64'd1, 64'd1, 64'd0, 64'd1,
                  1'b1, 64'd5, 64'd0, 64'd1, 4'b0000);
    // 2: ORR with register operand
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001, 64'd1, 64'd1, 64'd1, 64'd2,
                  1'b0, 64'd5, 64'd3, 64'd2, 4'b0000);
    // 3: ORR with immediate 2, branch 1 + 8
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0001, 64'd1, 64'd2, 64'd1, 64'd2,
                  1'b0, 64'd9, 64'd3, 64'd2, 4'b0000);
    // 4: pass B
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0111, 64'd0, 64'd0, 64'd0, 64'd2,
                  1'b0, 64'd0, 64'd2, 64'd2, 4'b0000);
    // 5: ADD FF..FE + 1, set flags -> 1000
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b0010, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0,
                  1'b0, 64'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'b0000);
    // 6: SUB 1 - 1, set flags -> 0110
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b0110, 64'd0, 64'd1, 64'd1, 64'd0,
                  1'b1, 64'd4, 64'd0, 64'd0, 4'b1000);
    // 7: ADD 5 + 7 without setFlags, flags show 0110
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0010, 64'h10, 64'd0, 64'd5, 64'd7,
                  1'b0, 64'h10, 64'd12, 64'd7, 4'b0110);
    // 8: NOR of zeros, negative branch offset, set flags -> 1000
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b1100, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0,
                  1'b0, 64'hFC, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'b0110);
    // 9: undefined code gives 0; shift drops imm MSBs; set flags -> 0100
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0011, 64'd0, 64'h4000_0000_0000_0001, 64'd5, 64'd3,
                  1'b1, 64'd4, 64'd0, 64'd3, 4'b1000);
    // 10: ADD signed overflow, set flags -> 1001
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0010, 64'd0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
                  1'b0, 64'd0, 64'h8000_0000_0000_0000, 64'd1, 4'b0100);
    // 11: SUB 0 - 1 with reset and setFlags together: reset wins -> 0000
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0110, 64'd0, 64'd0, 64'd0, 64'd1,
                  1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b1001);
    // 12: ADD FF..FF + 1 carries out to zero, set flags -> 0110
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0010, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                  1'b1, 64'd0, 64'd0, 64'd1, 4'b0000);
    // 13: idle, flags hold 0110
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 64'd0, 64'd0, 64'd0, 64'd0,
                  1'b1, 64'd0, 64'd0, 64'd0, 4'b0110);
    // 14: reset asserted, flags still 0110 during this cycle
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 64'd0, 64'd0, 64'd0, 64'd0,
                  1'b1, 64'd0, 64'd0, 64'd0, 4'b0110);
    // 15: flags cleared by the reset edge
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 64'd0, 64'd0, 64'd0, 64'd0,
                  1'b1, 64'd0, 64'd0, 64'd0, 4'b0000);

    // Bounded wait for the monitor to drain the scoreboard.
    drainWait = 0;
    while (expQueue.size() > 0 && drainWait < 10) begin
      @(posedge clk);
      drainWait++;
    end
    assertCount++;
    if (expQueue.size() != 0) begin
      failCount++;
      $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", expQueue.size());
    end
    assertCount++;
    if (vecIndex != 16) begin
      failCount++;
      $display("[TB] FAIL vector count: checked %0d, expected 16", vecIndex);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
